// File: rtl/idli_fetch_m_if.sv
`default_nettype none
// idli_fetch_m_if: memory-interface and core-side signals of the fetch unit.
// The master modport is the fetch unit; slave is the memory/core side.
interface idli_fetch_m_if;
  logic [1:0]  i_fet_ctr;
  logic [3:0]  i_fet_data;
  logic        i_fet_data_vld;
  logic        o_fet_redirect;
  logic [3:0]  o_fet_addr;
  logic        i_fet_br_req;
  logic [15:0] i_fet_br_addr;
  logic [15:0] o_fet_instr;
  logic        o_fet_instr_vld;
  logic        i_fet_instr_rdy;
  logic [15:0] o_fet_pc;

  modport master (
    input  i_fet_ctr, i_fet_data, i_fet_data_vld, i_fet_br_req, i_fet_br_addr, i_fet_instr_rdy,
    output o_fet_redirect, o_fet_addr, o_fet_instr, o_fet_instr_vld, o_fet_pc
  );

  modport slave (
    output i_fet_ctr, i_fet_data, i_fet_data_vld, i_fet_br_req, i_fet_br_addr, i_fet_instr_rdy,
    input  o_fet_redirect, o_fet_addr, o_fet_instr, o_fet_instr_vld, o_fet_pc
  );
endinterface
`default_nettype wire

// File: rtl/idli_fetch_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idli_fetch_m: nibble-serial instruction fetch with 2-entry buffer.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module idli_fetch_m (
  input  wire             i_fet_gck,
  input  wire             i_sqi_rst_n,
  idli_fetch_m_if.master  fet
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    ADDR  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] target;
  logic [15:0] fetch_pc;
  logic [11:0] partial;
  logic [15:0] buf_instr [2];
  logic [15:0] buf_pc    [2];
  logic [1:0]  count;

  logic [1:0]  ctr;
  logic        vld;
  logic        push;
  logic        pop;
  logic        overflow;
  logic        accept;
  logic [15:0] word;
  logic [3:0]  addr_nib;

  assign ctr      = fet.i_fet_ctr;
  assign vld      = fet.i_fet_data_vld;
  assign pop      = (count != 2'd0) && fet.i_fet_instr_rdy;
  assign push     = (state == RUN) && vld && (ctr == 2'd3);
  assign overflow = push && (count == 2'd2) && !pop;
  assign accept   = push && !overflow;
  assign word     = {fet.i_fet_data, partial};

  always_comb begin
    addr_nib = 4'd0;
    if (state == ADDR) begin
      case (ctr)
        2'd0:    addr_nib = target[15:12];
        2'd1:    addr_nib = target[11:8];
        2'd2:    addr_nib = target[7:4];
        default: addr_nib = target[3:0];
      endcase
    end
  end

  // Redirect is gated by reset so the pulse cannot appear while held in reset.
  assign fet.o_fet_redirect  = i_sqi_rst_n && (state == REDIR) && (ctr == 2'd3);
  assign fet.o_fet_addr      = addr_nib;
  assign fet.o_fet_instr_vld = (count != 2'd0);
  assign fet.o_fet_instr     = (count != 2'd0) ? buf_instr[0] : 16'd0;
  assign fet.o_fet_pc        = (count != 2'd0) ? buf_pc[0]    : 16'd0;

  always_ff @(posedge i_fet_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state        <= REDIR;
      target       <= 16'd0;
      fetch_pc     <= 16'd0;
      partial      <= 12'd0;
      count        <= 2'd0;
      buf_instr[0] <= 16'd0;
      buf_instr[1] <= 16'd0;
      buf_pc[0]    <= 16'd0;
      buf_pc[1]    <= 16'd0;
    end else if (fet.i_fet_br_req) begin
      state    <= REDIR;
      target   <= fet.i_fet_br_addr;
      fetch_pc <= fet.i_fet_br_addr;
      partial  <= 12'd0;
      count    <= 2'd0;
    end else begin
      case (state)
        REDIR: if (ctr == 2'd3) state <= ADDR;
        ADDR:  if (ctr == 2'd3) state <= WAIT;
        WAIT:  if (vld && ctr == 2'd3) state <= RUN;
        RUN: begin
          if (!vld) begin
            state   <= WAIT;
            partial <= 12'd0;
          end else begin
            case (ctr)
              2'd0: partial[3:0]  <= fet.i_fet_data;
              2'd1: partial[7:4]  <= fet.i_fet_data;
              2'd2: partial[11:8] <= fet.i_fet_data;
              default: begin
                partial <= 12'd0;
                // A dropped word is refetched from its own address.
                if (overflow) begin
                  state  <= REDIR;
                  target <= fetch_pc;
                end else begin
                  fetch_pc <= fetch_pc + 16'd1;
                end
              end
            endcase
          end
        end
        default: state <= REDIR;
      endcase

      if (pop && accept) begin
        if (count == 2'd2) begin
          buf_instr[0] <= buf_instr[1];
          buf_pc[0]    <= buf_pc[1];
          buf_instr[1] <= word;
          buf_pc[1]    <= fetch_pc;
        end else begin
          buf_instr[0] <= word;
          buf_pc[0]    <= fetch_pc;
        end
      end else if (pop) begin
        buf_instr[0] <= buf_instr[1];
        buf_pc[0]    <= buf_pc[1];
        count        <= count - 2'd1;
      end else if (accept) begin
        buf_instr[count[0]] <= word;
        buf_pc[count[0]]    <= fetch_pc;
        count               <= count + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/idli_fetch_m.md
IDLI_FETCH_M -- requirements
Module: idli_fetch_m

Interface
REQ-001 SHALL have port i_fet_gck, input, 1b: core clock (GCK), all flops rising-edge.
REQ-002 SHALL have port i_sqi_rst_n, input, 1b: reset, asynchronous, active-low.
REQ-003 SHALL have port i_fet_ctr, input, 2b (ctr_t): free-running GCK phase counter, 0..3 wrapping.
REQ-004 SHALL have port i_fet_data, input, 4b (slice_t): read nibble from memory interface.
REQ-005 SHALL have port i_fet_data_vld, input, 1b: i_fet_data carries fetched data this phase group.
REQ-006 SHALL have port o_fet_redirect, output, 1b: request to memory interface to restart its access.
REQ-007 SHALL have port o_fet_addr, output, 4b (slice_t): redirect address nibble to memory interface.
REQ-008 SHALL have port i_fet_br_req, input, 1b: single-GCK branch request from core.
REQ-009 SHALL have port i_fet_br_addr, input, 16b: branch target word address, valid with i_fet_br_req.
REQ-010 SHALL have port o_fet_instr, output, 16b: instruction at buffer head.
REQ-011 SHALL have port o_fet_instr_vld, output, 1b: buffer non-empty.
REQ-012 SHALL have port i_fet_instr_rdy, input, 1b: core accepts head this GCK.
REQ-013 SHALL have port o_fet_pc, output, 16b: word address of head instruction.

Function
REQ-014 SHALL implement states RUN, REDIR, ADDR, WAIT; transitions only as REQ-015..REQ-020 and REQ-024.
REQ-015 REDIR: o_fet_redirect SHALL be 1 only on the GCK with i_fet_ctr==3, then move to ADDR; 0 in all other states/phases.
REQ-016 ADDR: o_fet_addr SHALL present target MSB-first: ctr 0->[15:12], 1->[11:8], 2->[7:4], 3->[3:0]; move to WAIT after ctr==3.
REQ-017 Outside ADDR, o_fet_addr SHALL be 0.
REQ-018 WAIT: incoming nibbles SHALL be discarded; move to RUN on GCK with i_fet_data_vld==1 and ctr==3, so assembly starts at next ctr==0.
REQ-019 RUN: nibble at ctr k SHALL be written to assembly bits [4k+3:4k] (LS-nibble first) when i_fet_data_vld==1.
REQ-020 RUN with i_fet_data_vld==0 at any phase SHALL discard partial word and move to WAIT; fetch PC unchanged.
REQ-021 Word completes at ctr==3 in RUN with vld: {nibble3,assembly[11:0]} SHALL be pushed with fetch PC into buffer, visible at o_fet_instr next GCK; fetch PC increments by 1, wrapping 0xFFFF->0x0000.
REQ-022 Buffer SHALL be 2 entries, FIFO order; pop on o_fet_instr_vld && i_fet_instr_rdy; o_fet_instr/o_fet_pc SHALL be 0 when empty.
REQ-023 Push and pop same GCK SHALL both occur; a push when full with simultaneous pop SHALL be accepted.
REQ-024 Push when full without pop (overflow): word dropped, target := PC of dropped word, fetch PC := same, state -> REDIR; buffered entries kept.
REQ-025 i_fet_br_req in any state: buffer flushed, partial word discarded, target and fetch PC := i_fet_br_addr, state -> REDIR, next GCK.
REQ-026 i_fet_br_req SHALL take priority over overflow, push and pop in the same GCK; o_fet_instr_vld 0 next GCK.
REQ-027 i_fet_br_req while in REDIR before ctr==3 SHALL replace target; redirect pulse uses latest target.
REQ-028 Pop of an empty buffer SHALL have no effect.

Reset
REQ-029 On i_sqi_rst_n low: state=REDIR, target=0x0000, fetch PC=0x0000, buffer empty, assembly cleared.
REQ-030 Reset outputs: o_fet_redirect=0, o_fet_addr=0, o_fet_instr_vld=0, o_fet_instr=0, o_fet_pc=0.
REQ-031 Reset mid-operation SHALL abandon any transfer; first redirect after release at first ctr==3.

Verification
REQ-032 Boot: release reset at ctr=1 -> redirect pulse at ctr=3, o_fet_addr 0,0,0,0, then WAIT.
REQ-033 Stream: vld=1, nibbles 4,3,2,1 then D,C,B,A, rdy=1 -> instr 0x1234 pc 0x0000, then 0xABCD pc 0x0001.
REQ-034 Overflow: rdy=0, three words from pc 0x0010 -> two buffered (0x0010,0x0011), redirect with addr nibbles 0,0,1,2.
REQ-035 Branch: br_req addr 0xBEEF with overflow same GCK -> buffer flushed, vld 0, redirect, o_fet_addr B,E,E,F.
REQ-036 vld drop at ctr=2 mid-word -> partial discarded, next complete word pushed with unchanged pc.
REQ-037 Wrap: fetch PC 0xFFFF word complete -> next word pc 0x0000.
